mem_loader: RTL
===============

Name: mem_loader

Overview:
- Byte-stream program/data loader that sits directly upstream of the word-addressed data RAM.
- In load mode it takes bytes from a valid/ready source (UART receiver or testbench), assembles them into little-endian words, and writes them to consecutive RAM addresses from 0.
- It holds the CPU in reset while a load is in progress.
- Outside load mode it passes the CPU's RAM write/address/data signals straight through to the RAM.

Parameters:
- WORD_WIDTH, 32, RAM word width in bits; must be a multiple of 8; BPW = WORD_WIDTH/8 bytes per word.
- ENTRIES, 100, RAM depth in words; AW = $clog2(ENTRIES).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous active-low reset.
- Load_En  in  1  request a load; sampled in IDLE.
- Byte_Valid  in  1  Byte_Data is valid this cycle.
- Byte_Data  in  8  stream byte.
- Byte_Ready  out  1  loader accepts Byte_Data this cycle.
- Cpu_WE  in  1  CPU store enable (pass-through).
- Cpu_A  in  AW  CPU word address (pass-through).
- Cpu_WD  in  WORD_WIDTH  CPU store data (pass-through).
- Ram_WE  out  1  RAM write enable.
- Ram_A  out  AW  RAM word address.
- Ram_WD  out  WORD_WIDTH  RAM write data.
- Cpu_Rst  out  1  active-low CPU reset.
- Busy  out  1  load in progress.
- Done  out  1  last load completed; sticky until the next load starts.
- Overflow  out  1  header count exceeded ENTRIES; sticky until the next load starts.

Behaviour:
- Clock and reset: single clock Clk. Rst is asynchronous, active-low, and forces all state regardless of Clk.
- Reset values: state=IDLE, word counter=0, byte index=0, assembly register=0, length=0, Done=0, Overflow=0, Busy=0, Byte_Ready=0.
- Stream format: 16-bit word count N, little-endian (low byte first), followed by N*BPW data bytes. Within each word, the first byte goes to bits [7:0], the next to [15:8], and so on.
- Byte transfer: a byte is taken on a rising edge only when Byte_Valid && Byte_Ready. Byte_Data is ignored otherwise.
- IDLE:
  - Byte_Ready=0, Busy=0, Cpu_Rst=Rst.
  - Ram_WE/Ram_A/Ram_WD = Cpu_WE/Cpu_A/Cpu_WD, combinationally.
  - If Load_En=1: go to LEN_LO, clear Done, Overflow, word counter and byte index.
- LEN_LO: Byte_Ready=1. A transfer latches length[7:0], then go to LEN_HI.
- LEN_HI:
  - Byte_Ready=1. A transfer latches length[15:8].
  - If the full length is 0, go to FINISH; otherwise go to DATA.
  - If length > ENTRIES, set Overflow=1.
- DATA:
  - Byte_Ready=1. Each transfer stores the byte in lane [byte index] and increments the byte index.
  - When the byte at index BPW-1 is taken, go to WRITE.
- WRITE (exactly one cycle):
  - Byte_Ready=0, Ram_WE=1 only if word counter < ENTRIES.
  - Ram_A = word counter truncated to AW bits. Ram_WD = assembled word.
  - Then increment the word counter and reset the byte index to 0.
  - If the incremented counter == length, go to FINISH; otherwise return to DATA.
  - Words beyond ENTRIES are consumed and not written.
- FINISH (one cycle): set Done=1, go to IDLE.
- Load-mode outputs: in all states except IDLE, Cpu_Rst=0, Busy=1, the Cpu_* inputs are ignored, and Ram_WE=0 except in WRITE.
- Throughput: with continuous Byte_Valid, the loader accepts BPW bytes and then inserts 1 bubble cycle per word.
- Load_En: deasserting it mid-load has no effect; the load completes. Load_En held high in IDLE after FINISH restarts a load on the next cycle.
- Reset mid-load: immediate return to IDLE. Partially written RAM contents remain. Done=0.

Test Plan:
- Reset/pass-through:
  - Assert Rst=0 -> all outputs at reset values.
  - Release Rst, set Cpu_WE=1, Cpu_A=5, Cpu_WD=32'hDEADBEEF -> Ram_WE=1, Ram_A=5, Ram_WD=32'hDEADBEEF in the same cycle; Cpu_Rst=1.
- Basic load:
  - Load_En pulse, then stream 02 00 | 78 56 34 12 | EF BE AD DE with Byte_Valid held high.
  - Expect Ram write (A=0, WD=32'h12345678), then Ram write (A=1, WD=32'hDEADBEEF), each with a one-cycle Byte_Ready=0 bubble.
  - Then Done=1, Busy=0, Cpu_Rst=1.
- Gapped stream: same stream with Byte_Valid toggling 1,0,1,0 -> identical RAM writes. No byte is taken while Byte_Valid=0.
- Zero length: stream 00 00 -> no Ram_WE pulse; Done=1 two cycles after the second byte is taken.
- Overflow with ENTRIES=4:
  - Header 06 00 -> Overflow=1 after the header.
  - Exactly 4 Ram_WE pulses at A=0..3; 24 data bytes consumed; Done=1.
- Reset mid-load: assert Rst=0 after the 5th byte -> IDLE immediately, Busy=0, Done=0, Cpu_Rst follows Rst; the next load then behaves normally.

Source files
------------

// File: rtl/mem_loader.sv
// Byte-stream loader: assembles little-endian words from a valid/ready byte
// source into RAM from address 0 while holding the CPU in reset.
module mem_loader #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ENTRIES    = 100,
  localparam int unsigned BPW       = WORD_WIDTH / 8,
  localparam int unsigned AW        = $clog2(ENTRIES),
  localparam int unsigned BW        = (BPW > 1) ? $clog2(BPW) : 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Load_En,
  input  logic                  Byte_Valid,
  input  logic [7:0]            Byte_Data,
  output logic                  Byte_Ready,
  input  logic                  Cpu_WE,
  input  logic [AW-1:0]         Cpu_A,
  input  logic [WORD_WIDTH-1:0] Cpu_WD,
  output logic                  Ram_WE,
  output logic [AW-1:0]         Ram_A,
  output logic [WORD_WIDTH-1:0] Ram_WD,
  output logic                  Cpu_Rst,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_FINISH
  } state_t;

  localparam logic [15:0] ENT16 = 16'(ENTRIES);
  localparam logic [BW-1:0] LAST_IDX = BW'(BPW - 1);

  state_t                state_q;
  logic [15:0]           cnt_q;
  logic [15:0]           len_q;
  logic [BW-1:0]         idx_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  take;
  logic [15:0]           len_full;
  logic [15:0]           cnt_inc;

  assign Byte_Ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
  assign take       = Byte_Valid && Byte_Ready;
  assign len_full   = {Byte_Data, len_q[7:0]};
  assign cnt_inc    = cnt_q + 16'd1;

  assign Busy     = (state_q != S_IDLE);
  assign Cpu_Rst  = (state_q == S_IDLE) ? Rst : 1'b0;
  assign Done     = done_q;
  assign Overflow = ovf_q;

  // Counter keeps running past ENTRIES so oversize streams are drained, not written.
  always_comb begin
    Ram_WE = 1'b0;
    Ram_A  = cnt_q[AW-1:0];
    Ram_WD = data_q;
    if (state_q == S_IDLE) begin
      Ram_WE = Cpu_WE;
      Ram_A  = Cpu_A;
      Ram_WD = Cpu_WD;
    end else if (state_q == S_WRITE) begin
      Ram_WE = (cnt_q < ENT16);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Load_En) begin
            state_q <= S_LEN_LO;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        S_LEN_LO: begin
          if (take) begin
            len_q[7:0] <= Byte_Data;
            state_q    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (take) begin
            len_q[15:8] <= Byte_Data;
            state_q     <= (len_full == 16'd0) ? S_FINISH : S_DATA;
            if (len_full > ENT16) ovf_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (take) begin
            data_q[idx_q*8 +: 8] <= Byte_Data;
            idx_q                <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          cnt_q   <= cnt_inc;
          idx_q   <= '0;
          state_q <= (cnt_inc == len_q) ? S_FINISH : S_DATA;
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
